// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legacy aliases and FSM encoding shared by the sequential ALU
package alu_pkg;
  localparam logic [2:0] LEG_ADD = 3'b010;
  localparam logic [2:0] LEG_SUB = 3'b011;
  localparam logic [2:0] LEG_SLL = 3'b100;
  localparam logic [2:0] LEG_SRL = 3'b101;
  localparam logic [2:0] LEG_ADD_ALT = 3'b110;
  localparam logic [2:0] LEG_SUB_ALT = 3'b111;
  localparam logic [3:0] ALU_NOOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = {1'b0, LEG_ADD};
  localparam logic [3:0] ALU_SUB = {1'b0, LEG_SUB};
  localparam logic [3:0] ALU_SLL = {1'b0, LEG_SLL};
  localparam logic [3:0] ALU_SRL = {1'b0, LEG_SRL};
  localparam logic [3:0] ALU_ADD_ALT = {1'b0, LEG_ADD_ALT};
  localparam logic [3:0] ALU_SUB_ALT = {1'b0, LEG_SUB_ALT};
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_SLT = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_MUL = 4'b1110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: fixed-latency WIDTH-cycle shift-add multiplier, low WIDTH bits of a*b
module alu_mul_iter #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  logic [WIDTH-1:0] a_reg, b_reg, acc;
  logic [SHAMT_W-1:0] count;
  logic busy;
  assign product = acc + (b_reg[0] ? a_reg : '0);
  assign done = busy && count == SHAMT_W'(WIDTH - 1);
  // load operands on start, then one shift-add step per cycle; product is taken on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc <= '0;
      count <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_reg <= a;
      b_reg <= b;
      acc <= '0;
      count <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= product;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      count <= count + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative multiplier
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  state_t state, state_next;
  logic [WIDTH-1:0] res, product;
  logic [WIDTH:0] sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic c, v, il, accept, is_mul, mul_done;
  assign shamt = src_b[SHAMT_W-1:0];
  assign sum = {1'b0, src_a} + {1'b0, src_b};
  assign diff = {1'b0, src_a} - {1'b0, src_b};
  assign is_mul = alu_control == ALU_MUL;
  assign in_ready = state == ST_IDLE || (state == ST_DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == ST_DONE;
  assign zero = alu_result == '0;
  assign negative = alu_result[WIDTH-1];
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(accept && is_mul),
    .a(src_a),
    .b(src_b),
    .done(mul_done),
    .product(product)
  );
  // single-cycle ops and their flags; undefined codes and NOOP yield zero
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    il = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_ADD_ALT: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1];
      end
      ALU_SUB, ALU_SUB_ALT: begin
        res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1];
      end
      ALU_SLL: res = src_a << shamt;
      ALU_SRL: res = src_a >> shamt;
      ALU_AND: res = src_a & src_b;
      ALU_OR: res = src_a | src_b;
      ALU_XOR: res = src_a ^ src_b;
      ALU_SRA: res = $unsigned($signed(src_a) >>> shamt);
      ALU_SLT: res = WIDTH'($signed(src_a) < $signed(src_b));
      ALU_SLTU: res = WIDTH'(src_a < src_b);
      ALU_ILLEGAL: il = 1'b1;
      default: ;
    endcase
  end
  // next state: a fresh acceptance wins, otherwise finish MUL or hold DONE under back-pressure
  always_comb begin
    state_next = accept ? (is_mul ? ST_MUL : ST_DONE)
               : state == ST_MUL ? (mul_done ? ST_DONE : ST_MUL)
               : (state == ST_DONE && !out_ready) ? ST_DONE : ST_IDLE;
  end
  // state plus result bundle, loaded on a non-MUL acceptance or multiplier completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      alu_result <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_mul) begin
        alu_result <= res;
        carry <= c;
        overflow <= v;
        illegal <= il;
      end else if (mul_done) begin
        alu_result <= product;
        carry <= 1'b0;
        overflow <= 1'b0;
        illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src_a, src_b, alu_result;
  logic [3:0] alu_control;
  logic zero, negative, carry, overflow, illegal;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct packed {
    logic [31:0] r;
    logic c;
    logic v;
    logic il;
  } exp_t;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .src_a(src_a),
    .src_b(src_b),
    .alu_control(alu_control),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_result(alu_result),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow),
    .illegal(illegal)
  );
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] u;
    int sh;
    e = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      4'd2, 4'd6: begin
        u = {32'b0, a} + {32'b0, b};
        e.r = u[31:0];
        e.c = u[32];
        s = sa + sb;
        e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd3, 4'd7: begin
        e.r = a - b;
        e.c = a < b;
        s = sa - sb;
        e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd4: e.r = a << sh;
      4'd5: e.r = a >> sh;
      4'd8: e.r = a & b;
      4'd9: e.r = a | b;
      4'd10: e.r = a ^ b;
      4'd11: e.r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd12: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd13: e.r = (a < b) ? 32'd1 : 32'd0;
      4'd14: e.r = a * b;
      4'd15: e.il = 1'b1;
      default: ;
    endcase
    return e;
  endfunction
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
  endtask
  task automatic check_bundle(string tag, exp_t e);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'({alu_result, zero, negative, carry, overflow, illegal}),
          64'({e.r, e.r == 32'd0, e.r[31], e.c, e.v, e.il}));
  endtask
  task automatic do_op(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    drive(op, a, b);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_bundle(tag, model(op, a, b));
    tick();
    check({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask
  task automatic do_mul(string tag, logic [31:0] a, logic [31:0] b);
    drive(4'd14, a, b);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check({tag, "_busy"}, 64'({in_ready, out_valid}), 64'd0);
      tick();
    end
    check_bundle(tag, model(4'd14, a, b));
    tick();
  endtask
  initial begin
    exp_t q[$];
    logic [3:0] ops [13] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                              4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    int seen;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_control = 4'd0;
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_hs", 64'({in_ready, out_valid}), 64'b10);
    check("reset_out", 64'({alu_result, zero, negative, carry, overflow, illegal}),
          64'({32'd0, 5'b10000}));
    do_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1);
    do_op("sub_0m1", 4'd3, 32'h0, 32'h1);
    do_op("sra_min", 4'd11, 32'h8000_0000, 32'd31);
    do_op("slt", 4'd12, 32'hFFFF_FFFF, 32'h1);
    do_op("sltu", 4'd13, 32'hFFFF_FFFF, 32'h1);
    do_op("sll0", 4'd4, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    do_op("srl_hi", 4'd5, 32'hDEAD_BEEF, 32'h0000_0124);
    do_op("illegal", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op("noop", 4'd0, 32'h1234_5678, 32'h1);
    do_op("sub_alt", 4'd7, 32'h8000_0000, 32'h1);
    for (int i = 0; i < 40; i++)
      do_op("rand", ops[$urandom_range(12)], $urandom, (i % 3 == 0) ? $urandom_range(31) : $urandom);
    do_mul("mul_dir", 32'h0001_0003, 32'h0000_0005);
    for (int i = 0; i < 3; i++) do_mul("mul_rand", $urandom, $urandom);
    drive(4'd8, 32'h0000_F0F0, 32'h0000_0FF0);
    out_ready = 1'b0;
    tick();
    drive(4'd10, 32'hA5A5_0F0F, 32'h0F0F_FFFF);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({out_valid, in_ready, alu_result}), 64'({2'b10, 32'h0000_00F0}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_bundle("bp_xor", model(4'd10, 32'hA5A5_0F0F, 32'h0F0F_FFFF));
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(4'd2, $urandom, $urandom);
      q.push_back(model(4'd2, src_a, src_b));
      check("stream_rdy", 64'(in_ready), 64'd1);
      tick();
      check_bundle("stream", q.pop_front());
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 64'(out_valid), 64'd0);
    drive(4'd14, 32'h3, 32'h5);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mul", 64'({in_ready, out_valid, zero, alu_result}), 64'({3'b101, 32'd0}));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst_no_stale", 64'(seen), 64'd0);
    do_op("post_rst", 4'd9, 32'h00FF_0000, 32'h0000_00FF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds configurable WIDTH, logic/compare/arithmetic-shift ops and status flags.
- Adds an iterative shift-add multiplier.
- Operands enter through a valid/ready input channel; results and flags leave through a registered valid/ready output channel.
- Sits between the register-read stage and writeback, and can stall the pipeline during MUL.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from src_b[SHAMT_W-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B / shift amount
- alu_control  input  4  operation code
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts result
- alu_result  output  WIDTH  registered result
- zero  output  1  alu_result == 0
- negative  output  1  alu_result[WIDTH-1]
- carry  output  1  ADD: carry-out; SUB: borrow (a <u b); otherwise 0
- overflow  output  1  signed overflow for ADD/SUB; otherwise 0
- illegal  output  1  alu_control was 4'b1111

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (reset).
- Opcodes (4-bit; legacy 3-bit codes preserved with a leading 0):
  - 0000 NOOP → result 0
  - 0010/0110 ADD
  - 0011/0111 SUB
  - 0100 SLL
  - 0101 SRL
  - 1000 AND
  - 1001 OR
  - 1010 XOR
  - 1011 SRA (sign-filling)
  - 1100 SLT (signed, result 0/1)
  - 1101 SLTU
  - 1110 MUL (low WIDTH bits of a*b; identical for signed and unsigned)
  - 1111 illegal → result 0, illegal = 1
- Arithmetic is modulo 2^WIDTH. Shifts use only src_b[SHAMT_W-1:0]; upper bits are ignored.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready = 1. On in_valid:
    - non-MUL → compute, register result and flags, go to DONE.
    - MUL → latch a, b, clear accumulator, count = 0, go to MUL.
  - MUL: in_ready = 0. Each cycle: if b_reg[0], acc += a_reg; then a_reg <<= 1, b_reg >>= 1, count++. After WIDTH iterations, register the result and go to DONE. No early termination; latency is fixed.
  - DONE: out_valid = 1. Output bundle is held stable until out_ready.
    - out_ready=1 and in_valid=0 → IDLE.
    - out_ready=1 and in_valid=1 → in_ready = 1; the new bundle is accepted in the same cycle (non-MUL → stay in DONE with new result; MUL → go to MUL).
    - out_ready=0 → in_ready = 0, hold.
- Latency, acceptance to out_valid:
  - non-MUL: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput: non-MUL one per cycle with out_ready held high; MUL one per WIDTH+1 cycles.
- Flags are registered together with alu_result and are valid only while out_valid = 1.
- zero and negative are derived from the registered result.
- MUL flags: carry = 0, overflow = 0; zero and negative follow the result.
- Reset values:
  - state = IDLE, out_valid = 0, in_ready = 1 (combinational from IDLE).
  - alu_result = 0, zero = 1, negative, carry, overflow, illegal = 0.
  - Multiplier registers and count cleared.
- Reset mid-MUL or mid-DONE: operation is dropped and no output is produced; the next cycle behaves as IDLE.
- Boundaries:
  - Shift by 0 returns src_a.
  - SRA of the most-negative value by WIDTH-1 returns all ones.
  - SUB 0-1: result all ones, carry = 1, overflow = 0.
  - ADD max_pos+1: overflow = 1, negative = 1.
- No X on any output for any opcode.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (ALU_NOOP … ALU_MUL, ALU_ILLEGAL).
  - FSM state encoding.
  - Legacy 3-bit aliases for the decoder.
- One sub-module, alu_mul_iter: the WIDTH-cycle shift-add multiplier with start/done signals.
- Combinational ops and flag logic stay in alu_seq.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 with out_ready = 1 → one cycle later out_valid = 1, result 0x80000000, overflow = 1, negative = 1, carry = 0.
- SUB 0−1 → result 0xFFFFFFFF, carry = 1, overflow = 0. Then SRA 0x80000000 by 31 → 0xFFFFFFFF. Then SLT 0xFFFFFFFF,1 → 1; SLTU 0xFFFFFFFF,1 → 0.
- MUL 0x0001_0003 × 0x0000_0005 → in_ready low for 32 cycles; out_valid exactly 33 cycles after acceptance; result 0x0005_000F.
- Back-pressure: out_ready = 0 for 5 cycles after an AND 0xF0F0,0x0FF0 → alu_result stays 0x00F0 and in_ready stays 0. Raising out_ready with a queued XOR is accepted in the same cycle, with result on the next cycle.
- Stream 8 back-to-back ADDs with out_ready = 1 → 8 results on 8 consecutive cycles, in order, with no bubbles.
- Assert reset at MUL iteration 10 → next cycle state IDLE, out_valid = 0, zero = 1, and no stale result ever appears. Opcode 4'b1111 → result 0, illegal = 1.
